odo_round_key_bank: RTL and testbench
=====================================

Name: odo_round_key_bank

Overview:
- Parametrised, runtime-programmable round-key store for the Odo hashing core.
- Replaces fixed per-channel key ROMs with one double-buffered table of NUM_CH channels x NUM_PERIODS periods x KEY_W bits.
- Firmware programs the shadow bank and commits it at an epoch change.
- On request, the block streams the NUM_CH keys of one period, in channel order, over a valid/ready handshake to the round pipeline.

Parameters:
- KEY_W, 10: width of one round key.
- NUM_PERIODS, 9: number of valid periods (0..NUM_PERIODS-1).
- PERIOD_W, 4: width of period fields; must satisfy 2**PERIOD_W >= NUM_PERIODS.
- NUM_CH, 8: channels (keys) per period.
- CH_W, 3: width of channel fields; must satisfy 2**CH_W >= NUM_CH.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  write strobe to the shadow bank.
- cfg_period  in  PERIOD_W  write period index.
- cfg_ch  in  CH_W  write channel index.
- cfg_key  in  KEY_W  write data.
- cfg_commit  in  1  one-cycle pulse: swap the active and shadow banks.
- active_bank  out  1  index of the bank currently used for new requests.
- commit_pending  out  1  a commit is waiting for the stream to end.
- req_valid  in  1  request valid.
- req_period  in  PERIOD_W  requested period.
- req_ready  out  1  block idle; request can be accepted.
- key_valid  out  1  output key valid.
- key_ready  in  1  consumer accepts the key.
- key  out  KEY_W  round key.
- key_ch  out  CH_W  channel of the current key.
- key_last  out  1  marks channel NUM_CH-1.
- req_err  out  1  one-cycle pulse: out-of-range request was dropped.

Behaviour:
- Reset (async assert, sync release):
  - Both banks are zeroed; active_bank=0; commit_pending=0.
  - key_valid=0, key=0, key_ch=0, key_last=0, req_err=0.
  - FSM returns to IDLE, so req_ready=1 after reset.
  - Reset asserted mid-stream aborts the stream. No further key beats appear.
- Writes:
  - When cfg_we=1, cfg_key is stored at shadow[cfg_period][cfg_ch] on the clock edge. It is visible only after a commit.
  - Writes with cfg_period>=NUM_PERIODS or cfg_ch>=NUM_CH are ignored.
  - Writes are legal in any FSM state. They never touch the bank being streamed.
- Commit:
  - If cfg_commit=1 and the FSM is in IDLE with no request accepted that cycle, active_bank toggles on that edge.
  - Otherwise commit_pending is set to 1.
  - A pending commit applies on the edge that completes the final handshake (key_last beat) or on the req_err return. commit_pending clears on the same edge.
  - Repeated commits while pending collapse into one swap.
  - If cfg_we and cfg_commit occur in the same cycle, the write lands in the old shadow, which becomes active.
  - Banks are not copied on swap. The new shadow holds the previous epoch's keys.
- FSM states: IDLE, STREAM, ERR.
  - IDLE:
    - req_ready=1.
    - If req_valid=1 and req_period<NUM_PERIODS: capture the period and the active bank. Go to STREAM. On the same edge, register key=bank[period][0], key_ch=0, key_valid=1, and key_last=(NUM_CH==1). Latency from acceptance to first beat is 1 cycle.
    - If req_valid=1 and req_period>=NUM_PERIODS: go to ERR.
  - ERR:
    - req_err=1 for exactly one cycle, req_ready=0.
    - Then return to IDLE.
  - STREAM:
    - req_ready=0.
    - key, key_ch and key_last hold stable while key_valid=1 and key_ready=0.
    - On a handshake with key_ch<NUM_CH-1, the next edge presents channel key_ch+1 from the captured bank and period, with no bubble.
    - On a handshake with key_last=1, key_valid drops to 0 and the FSM returns to IDLE. req_ready=1 in the following cycle; back-to-back requests have a one-cycle gap.
- key_ch increments in binary and does not wrap within a request.

Test Plan:
- Reset, write shadow[0][0..7]=0x03b,0x183,0x2cf,0x2dc,0x246,0x0b7,0x1d8,0x2ce, then request period 0 with no commit -> 8 beats of key=0x000, active_bank=0.
- Commit in IDLE, then request period 0 with key_ready=1 -> active_bank=1; beats 0x03b..0x2ce on consecutive cycles, first beat 1 cycle after acceptance, key_last on key_ch=7.
- Same stream with key_ready toggling 1/0 -> each key held stable through stall cycles; no duplicated or dropped channels.
- cfg_commit during beat 3 of a stream after writing shadow[0][0]=0x3f2 -> commit_pending=1; remaining beats from the old bank; swap on the last-beat edge; the next request returns 0x3f2 on channel 0.
- req_period=9 -> req_err pulses 1 cycle, no key_valid, req_ready back to 1 after two cycles; writes with cfg_period=12 leave all contents unchanged.
- Assert rst_n=0 mid-stream at key_ch=4 -> key_valid=0 immediately, active_bank=0, all subsequent reads return 0x000.

Source files
------------

// File: rtl/odo_round_key_bank.sv
// Double-buffered round-key table for the Odo hashing core.
// Streams the NUM_CH keys of one period over a valid/ready handshake.
module odo_round_key_bank #(
   parameter int KEY_W       = 10,
   parameter int NUM_PERIODS = 9,
   parameter int PERIOD_W    = 4,
   parameter int NUM_CH      = 8,
   parameter int CH_W        = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_we,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [KEY_W-1:0]    cfg_key,
   input  logic                cfg_commit,
   output logic                active_bank,
   output logic                commit_pending,
   input  logic                req_valid,
   input  logic [PERIOD_W-1:0] req_period,
   output logic                req_ready,
   output logic                key_valid,
   input  logic                key_ready,
   output logic [KEY_W-1:0]    key,
   output logic [CH_W-1:0]     key_ch,
   output logic                key_last,
   output logic                req_err
);

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      ERR
   } state_t;

   state_t state;

   logic [KEY_W-1:0]    mem [2][NUM_PERIODS][NUM_CH];
   logic                cap_bank;
   logic [PERIOD_W-1:0] cap_period;
   logic [CH_W-1:0]     nxt_ch;
   logic                wr_ok;
   logic                req_ok;
   logic                hs;
   logic                done;
   logic                swap_now;

   assign wr_ok = cfg_we
                && (int'(cfg_period) < NUM_PERIODS)
                && (int'(cfg_ch) < NUM_CH);
   assign req_ok = int'(req_period) < NUM_PERIODS;
   assign hs = (state == STREAM) && key_valid && key_ready;
   assign done = (hs && key_last) || (state == ERR);
   assign nxt_ch = key_ch + CH_W'(1);

   // A commit seen in idle swaps at once; otherwise it waits for the
   // stream (or error) to finish so the streamed bank never changes.
   assign swap_now = (cfg_commit && (state == IDLE) && !req_valid)
                   || ((commit_pending || cfg_commit) && done);

   assign req_ready = (state == IDLE);
   assign req_err   = (state == ERR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++)
            for (int p = 0; p < NUM_PERIODS; p++)
               for (int c = 0; c < NUM_CH; c++)
                  mem[b][p][c] <= '0;
      end else if (wr_ok) begin
         mem[~active_bank][cfg_period][cfg_ch] <= cfg_key;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_bank    <= 1'b0;
         commit_pending <= 1'b0;
      end else if (swap_now) begin
         active_bank    <= ~active_bank;
         commit_pending <= 1'b0;
      end else if (cfg_commit) begin
         commit_pending <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         key_valid  <= 1'b0;
         key        <= '0;
         key_ch     <= '0;
         key_last   <= 1'b0;
         cap_bank   <= 1'b0;
         cap_period <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  if (req_ok) begin
                     state      <= STREAM;
                     cap_bank   <= active_bank;
                     cap_period <= req_period;
                     key        <= mem[active_bank][req_period][0];
                     key_ch     <= '0;
                     key_valid  <= 1'b1;
                     key_last   <= (NUM_CH == 1);
                  end else begin
                     state <= ERR;
                  end
               end
            end
            STREAM: begin
               if (key_ready) begin
                  if (key_last) begin
                     key_valid <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     key_ch   <= nxt_ch;
                     key      <= mem[cap_bank][cap_period][nxt_ch];
                     key_last <= (int'(nxt_ch) == NUM_CH - 1);
                  end
               end
            end
            ERR: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_odo_round_key_bank.sv
// Randomised bench for odo_round_key_bank against a two-table
// active/shadow model that swaps whole tables on commit.
module tb_odo_round_key_bank;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_we = 1'b0;
   logic [3:0] cfg_period = '0;
   logic [2:0] cfg_ch = '0;
   logic [9:0] cfg_key = '0;
   logic       cfg_commit = 1'b0;
   logic       active_bank;
   logic       commit_pending;
   logic       req_valid = 1'b0;
   logic [3:0] req_period = '0;
   logic       req_ready;
   logic       key_valid;
   logic       key_ready = 1'b0;
   logic [9:0] key;
   logic [2:0] key_ch;
   logic       key_last;
   logic       req_err;

   odo_round_key_bank dut (
      .clk(clk),
      .rst_n(rst_n),
      .cfg_we(cfg_we),
      .cfg_period(cfg_period),
      .cfg_ch(cfg_ch),
      .cfg_key(cfg_key),
      .cfg_commit(cfg_commit),
      .active_bank(active_bank),
      .commit_pending(commit_pending),
      .req_valid(req_valid),
      .req_period(req_period),
      .req_ready(req_ready),
      .key_valid(key_valid),
      .key_ready(key_ready),
      .key(key),
      .key_ch(key_ch),
      .key_last(key_last),
      .req_err(req_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [9:0] act [9][8];
   logic [9:0] shd [9][8];
   logic       m_act = 1'b0;
   logic       m_pend = 1'b0;

   function automatic void model_swap();
      logic [9:0] t;
      for (int p = 0; p < 9; p++)
         for (int c = 0; c < 8; c++) begin
            t = act[p][c];
            act[p][c] = shd[p][c];
            shd[p][c] = t;
         end
      m_act = ~m_act;
   endfunction

   function automatic void model_clear();
      for (int p = 0; p < 9; p++)
         for (int c = 0; c < 8; c++) begin
            act[p][c] = '0;
            shd[p][c] = '0;
         end
      m_act = 1'b0;
      m_pend = 1'b0;
   endfunction

   task automatic cfg_write(input int p, input int c, input logic [9:0] k);
      cfg_we = 1'b1;
      cfg_period = 4'(p);
      cfg_ch = 3'(c);
      cfg_key = k;
      @(negedge clk);
      cfg_we = 1'b0;
      if (p < 9 && c < 8) shd[p][c] = k;
   endtask

   task automatic commit_idle();
      cfg_commit = 1'b1;
      @(negedge clk);
      cfg_commit = 1'b0;
      model_swap();
      checks++;
      if (active_bank !== m_act || commit_pending !== 1'b0) begin
         errors++;
         $display("FAIL commit_idle: bank=%b pend=%b want bank=%b pend=0",
                  active_bank, commit_pending, m_act);
      end
   endtask

   // mode 0: always ready, 1: ready toggles 1/0, 2: random ready + writes
   task automatic run_stream(input int p, input int mode, input int cbeat);
      logic [9:0] exp [8];
      int b;
      int budget;
      bit rdy;
      bit cm_done;
      int wp;
      int wc;
      logic [9:0] wk;
      for (int c = 0; c < 8; c++) exp[c] = act[p][c];
      cm_done = 0;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL stream_start p%0d: req_ready=%b want 1", p, req_ready);
      end
      req_valid = 1'b1;
      req_period = 4'(p);
      key_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      b = 0;
      budget = 0;
      while (b < 8 && budget < 100) begin
         budget++;
         checks++;
         if (key_valid !== 1'b1 || key_ch !== 3'(b) || key !== exp[b]
             || key_last !== (b == 7) || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL stream p%0d beat%0d: v=%b ch=%0d key=%h last=%b rdy=%b want v=1 ch=%0d key=%h last=%b rdy=0",
                     p, b, key_valid, key_ch, key, key_last, req_ready,
                     b, exp[b], (b == 7));
         end
         checks++;
         if (active_bank !== m_act || commit_pending !== m_pend) begin
            errors++;
            $display("FAIL stream_bank p%0d beat%0d: bank=%b pend=%b want bank=%b pend=%b",
                     p, b, active_bank, commit_pending, m_act, m_pend);
         end
         if (mode == 0) rdy = 1'b1;
         else if (mode == 1) rdy = (budget % 2 == 1);
         else rdy = ($urandom % 2 == 0);
         key_ready = rdy;
         if (b == cbeat && !cm_done) begin
            cfg_commit = 1'b1;
            cm_done = 1;
            m_pend = 1'b1;
         end
         if (mode == 2 && $urandom % 3 == 0) begin
            wp = int'($urandom % 16);
            wc = int'($urandom % 8);
            wk = 10'($urandom);
            cfg_we = 1'b1;
            cfg_period = 4'(wp);
            cfg_ch = 3'(wc);
            cfg_key = wk;
            if (wp < 9) shd[wp][wc] = wk;
         end
         @(negedge clk);
         cfg_commit = 1'b0;
         cfg_we = 1'b0;
         if (rdy) begin
            if (b == 7 && m_pend) begin
               model_swap();
               m_pend = 1'b0;
            end
            b++;
         end
      end
      key_ready = 1'b0;
      checks++;
      if (budget >= 100) begin
         errors++;
         $display("FAIL stream_timeout p%0d: reached beat %0d want 8", p, b);
      end
      checks++;
      if (key_valid !== 1'b0 || req_ready !== 1'b1
          || active_bank !== m_act || commit_pending !== m_pend) begin
         errors++;
         $display("FAIL stream_end p%0d: v=%b rdy=%b bank=%b pend=%b want v=0 rdy=1 bank=%b pend=%b",
                  p, key_valid, req_ready, active_bank, commit_pending,
                  m_act, m_pend);
      end
   endtask

   task automatic test_reset();
      model_clear();
      #1;
      checks++;
      if (key_valid !== 1'b0 || key !== 10'h0 || key_ch !== 3'd0
          || key_last !== 1'b0 || req_err !== 1'b0 || active_bank !== 1'b0
          || commit_pending !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset: v=%b key=%h ch=%0d last=%b err=%b bank=%b pend=%b rdy=%b want all 0 rdy=1",
                  key_valid, key, key_ch, key_last, req_err, active_bank,
                  commit_pending, req_ready);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_shadow_invisible();
      logic [9:0] v [8];
      v = '{10'h03b, 10'h183, 10'h2cf, 10'h2dc,
            10'h246, 10'h0b7, 10'h1d8, 10'h2ce};
      for (int c = 0; c < 8; c++) cfg_write(0, c, v[c]);
      run_stream(0, 0, -1);
   endtask

   task automatic test_commit_stream();
      commit_idle();
      run_stream(0, 0, -1);
      run_stream(0, 1, -1);
   endtask

   task automatic test_commit_mid_stream();
      cfg_write(0, 0, 10'h3f2);
      run_stream(0, 0, 3);
      run_stream(0, 0, -1);
   endtask

   task automatic test_err();
      req_valid = 1'b1;
      req_period = 4'd9;
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (req_err !== 1'b1 || req_ready !== 1'b0 || key_valid !== 1'b0) begin
         errors++;
         $display("FAIL err_pulse: err=%b rdy=%b v=%b want err=1 rdy=0 v=0",
                  req_err, req_ready, key_valid);
      end
      @(negedge clk);
      checks++;
      if (req_err !== 1'b0 || req_ready !== 1'b1 || key_valid !== 1'b0) begin
         errors++;
         $display("FAIL err_return: err=%b rdy=%b v=%b want err=0 rdy=1 v=0",
                  req_err, req_ready, key_valid);
      end
      for (int p = 9; p < 16; p++)
         for (int c = 0; c < 8; c++) cfg_write(p, c, 10'($urandom));
      for (int p = 0; p < 9; p++) run_stream(p, 0, -1);
      commit_idle();
      for (int p = 0; p < 9; p++) run_stream(p, 0, -1);
   endtask

   task automatic test_same_cycle();
      cfg_we = 1'b1;
      cfg_period = 4'd5;
      cfg_ch = 3'd2;
      cfg_key = 10'h1a5;
      cfg_commit = 1'b1;
      @(negedge clk);
      cfg_we = 1'b0;
      cfg_commit = 1'b0;
      shd[5][2] = 10'h1a5;
      model_swap();
      run_stream(5, 0, -1);
   endtask

   task automatic test_random();
      for (int it = 0; it < 25; it++) begin
         for (int w = 0; w < 4; w++)
            cfg_write(int'($urandom % 16), int'($urandom % 8), 10'($urandom));
         if ($urandom % 3 == 0) commit_idle();
         run_stream(int'($urandom % 9), 2,
                    ($urandom % 2 == 0) ? -1 : int'($urandom % 8));
      end
   endtask

   task automatic test_reset_mid();
      int budget;
      commit_idle();
      req_valid = 1'b1;
      req_period = 4'd0;
      key_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      budget = 0;
      while (key_ch !== 3'd4 && budget < 20) begin
         budget++;
         @(negedge clk);
      end
      checks++;
      if (budget >= 20) begin
         errors++;
         $display("FAIL reset_mid_reach: ch=%0d want 4", key_ch);
      end
      cfg_commit = 1'b1;
      rst_n = 1'b0;
      #1;
      cfg_commit = 1'b0;
      checks++;
      if (key_valid !== 1'b0 || active_bank !== 1'b0
          || commit_pending !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid: v=%b bank=%b pend=%b rdy=%b want v=0 bank=0 pend=0 rdy=1",
                  key_valid, active_bank, commit_pending, req_ready);
      end
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_quiet: v=%b want 0", key_valid);
         end
      end
      key_ready = 1'b0;
      for (int p = 0; p < 9; p++) run_stream(p, 0, -1);
      commit_idle();
      for (int p = 0; p < 9; p++) run_stream(p, 1, -1);
   endtask

   initial begin
      test_reset();
      test_shadow_invisible();
      test_commit_stream();
      test_commit_mid_stream();
      test_err();
      test_same_cycle();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
